// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Holds the FSM encoding, EX/MEM control-bit positions and byte-enable patterns.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memState_t;

    // Bit positions of the memory-related flags inside the EX/MEM control word
    localparam int MEMREAD  = 2;
    localparam int MEMWRITE = 4;
    localparam int REGWRITE = 6;
    localparam int WORD     = 8;

    localparam logic [3:0] BE_NONE  = 4'h0;
    localparam logic [3:0] BE_BYTE0 = 4'h1;
    localparam logic [3:0] BE_WORD  = 4'hF;

    function automatic logic [3:0] laneEnable(input logic [1:0] lane);
        return BE_BYTE0 << lane;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: byte enables, store-data replication and
// zero-extended load extraction for byte or word accesses.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        word,
    input  logic [31:0] storeData,
    input  logic [31:0] readData,
    output logic [3:0]  byteEn,
    output logic [31:0] wData,
    output logic [31:0] loadData
);

    always_comb begin
        byteEn   = BE_NONE;
        wData    = storeData;
        loadData = readData;
        if (word) begin
            byteEn = BE_WORD;
        end else begin
            byteEn   = laneEnable(lane);
            wData    = {4{storeData[7:0]}};
            loadData = {24'd0, readData[{lane, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs a req/ack data-memory transaction for loads/stores,
// stalls upstream while it is outstanding and drives the MEM/WB registers.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       inResult,
    input  logic [31:0]       inReadRegister2,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic              inRegWrite,
    input  logic              inWord,
    input  logic [4:0]        inRd,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    output logic [3:0]        memByteEn,
    input  logic [31:0]       memRData,
    input  logic              memAck,
    output logic [31:0]       outResult,
    output logic [31:0]       outReadData,
    output logic [4:0]        outRd,
    output logic              outRegWrite,
    output logic              outMemToReg,
    output logic              misalign,
    output logic              busErr
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    memState_t        state, stateNext;
    logic [CNT_W-1:0] counter;
    logic [31:0]      resultReg;
    logic [31:0]      loadDataReg;
    logic [4:0]       rdReg;
    logic             regWriteReg;
    logic             readReg;
    logic             errReg;
    logic [1:0]       laneReg;
    logic             wordReg;

    logic        access;
    logic        aligned;
    logic        timeoutHit;
    logic [1:0]  laneSel;
    logic        wordSel;
    logic [3:0]  laneByteEn;
    logic [31:0] laneWData;
    logic [31:0] laneLoad;
    logic [31:0] alignedAddr;

    assign access      = inMemRead | inMemWrite;
    assign aligned     = ~inWord | (inResult[1:0] == 2'b00);
    assign timeoutHit  = (counter == CNT_LAST);
    assign alignedAddr = {inResult[31:2], 2'b00};
    assign stall       = ((state == IDLE) & access & aligned) | (state == REQ);

    // Lane steering follows the live instruction in IDLE and the latched one afterwards
    assign laneSel = (state == IDLE) ? inResult[1:0] : laneReg;
    assign wordSel = (state == IDLE) ? inWord : wordReg;

    mem_byte_lane uLane (
        .lane      (laneSel),
        .word      (wordSel),
        .storeData (inReadRegister2),
        .readData  (memRData),
        .byteEn    (laneByteEn),
        .wData     (laneWData),
        .loadData  (laneLoad)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (access && aligned) stateNext = REQ;
            REQ:     if (memAck || timeoutHit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            counter     <= '0;
            resultReg   <= '0;
            loadDataReg <= '0;
            rdReg       <= '0;
            regWriteReg <= 1'b0;
            readReg     <= 1'b0;
            errReg      <= 1'b0;
            laneReg     <= '0;
            wordReg     <= 1'b0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWData    <= '0;
            memByteEn   <= '0;
            outResult   <= '0;
            outReadData <= '0;
            outRd       <= '0;
            outRegWrite <= 1'b0;
            outMemToReg <= 1'b0;
            misalign    <= 1'b0;
            busErr      <= 1'b0;
        end else begin
            state    <= stateNext;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (!access || !aligned) begin
                        outResult   <= inResult;
                        outRd       <= inRd;
                        outRegWrite <= inRegWrite & ~access;
                        outMemToReg <= 1'b0;
                        misalign    <= access;
                    end else begin
                        // Dual read/write flags resolve to a write
                        resultReg   <= inResult;
                        rdReg       <= inRd;
                        regWriteReg <= inRegWrite;
                        readReg     <= inMemRead & ~inMemWrite;
                        laneReg     <= inResult[1:0];
                        wordReg     <= inWord;
                        errReg      <= 1'b0;
                        counter     <= '0;
                        memReq      <= 1'b1;
                        memWe       <= inMemWrite;
                        memAddr     <= alignedAddr[ADDR_W-1:0];
                        memWData    <= laneWData;
                        memByteEn   <= laneByteEn;
                        outRegWrite <= 1'b0;
                    end
                end
                REQ: begin
                    outRegWrite <= 1'b0;
                    counter     <= counter + 1'b1;
                    if (memAck) begin
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        if (readReg) loadDataReg <= laneLoad;
                    end else if (timeoutHit) begin
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        busErr <= 1'b1;
                        errReg <= 1'b1;
                    end
                end
                DONE: begin
                    outResult   <= resultReg;
                    outRd       <= rdReg;
                    outReadData <= loadDataReg;
                    outRegWrite <= regWriteReg & ~errReg;
                    outMemToReg <= readReg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions, a memory
// responder model, and a monitor comparing MEM/WB outputs on each retire.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] result;
        logic [31:0] readData;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memToReg;
        logic        mis;
        logic        err;
    } wbExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } reqExp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] inResult = '0;
    logic [31:0] inReadRegister2 = '0;
    logic        inMemRead = 1'b0;
    logic        inMemWrite = 1'b0;
    logic        inRegWrite = 1'b0;
    logic        inWord = 1'b0;
    logic [4:0]  inRd = '0;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic [31:0] memRData;
    logic        memAck;
    logic [31:0] outResult;
    logic [31:0] outReadData;
    logic [4:0]  outRd;
    logic        outRegWrite;
    logic        outMemToReg;
    logic        misalign;
    logic        busErr;

    int checks = 0;
    int errors = 0;
    logic tbValid = 1'b0;
    logic armed = 1'b0;
    int ackDelay = 0;
    logic [31:0] ackData = '0;
    wbExp_t  expQ[$];
    reqExp_t reqQ[$];

    always #5 clock = ~clock;

    mem_access_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .inResult        (inResult),
        .inReadRegister2 (inReadRegister2),
        .inMemRead       (inMemRead),
        .inMemWrite      (inMemWrite),
        .inRegWrite      (inRegWrite),
        .inWord          (inWord),
        .inRd            (inRd),
        .stall           (stall),
        .memReq          (memReq),
        .memWe           (memWe),
        .memAddr         (memAddr),
        .memWData        (memWData),
        .memByteEn       (memByteEn),
        .memRData        (memRData),
        .memAck          (memAck),
        .outResult       (outResult),
        .outReadData     (outReadData),
        .outRd           (outRd),
        .outRegWrite     (outRegWrite),
        .outMemToReg     (outMemToReg),
        .misalign        (misalign),
        .busErr          (busErr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Retire handshake: instruction presented and not stalled at the edge
    always @(negedge clock) armed = tbValid && !stall && reset_n;

    always @(posedge clock) begin
        if (armed) begin
            #3;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got retire expected none");
            end else begin
                wbExp_t e;
                e = expQ.pop_front();
                check("outResult", outResult, e.result);
                check("outReadData", outReadData, e.readData);
                check("outRd", {27'd0, outRd}, {27'd0, e.rd});
                check("outRegWrite", {31'd0, outRegWrite}, {31'd0, e.regWrite});
                check("outMemToReg", {31'd0, outMemToReg}, {31'd0, e.memToReg});
                check("misalign", {31'd0, misalign}, {31'd0, e.mis});
                check("busErr", {31'd0, busErr}, {31'd0, e.err});
                $display("retire res=%h rd=%0d rw=%b m2r=%b rdata=%h mis=%b err=%b",
                         outResult, outRd, outRegWrite, outMemToReg, outReadData, misalign, busErr);
            end
        end
    end

    // Memory responder: checks each request, acks after ackDelay REQ cycles (0 = never)
    initial begin
        memAck = 1'b0;
        memRData = '0;
        forever begin
            @(negedge clock);
            if (memReq === 1'b1) begin
                if (reqQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got memReq=1 expected 0 addr=%h", memAddr);
                end else begin
                    reqExp_t r;
                    r = reqQ.pop_front();
                    check("memAddr", memAddr, r.addr);
                    check("memByteEn", {28'd0, memByteEn}, {28'd0, r.be});
                    check("memWData", memWData, r.wd);
                    check("memWe", {31'd0, memWe}, {31'd0, r.we});
                end
                for (int c = 1; memReq === 1'b1; c++) begin
                    if (c == ackDelay) begin
                        memAck = 1'b1;
                        memRData = ackData;
                        @(negedge clock);
                        memAck = 1'b0;
                        break;
                    end
                    @(negedge clock);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] res, input logic [31:0] st, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic rw, input logic wd,
                         input logic valid);
        inResult = res;
        inReadRegister2 = st;
        inRd = rd;
        inMemRead = mr;
        inMemWrite = mw;
        inRegWrite = rw;
        inWord = wd;
        tbValid = valid;
    endtask

    task automatic issue(input string name,
                         input logic [31:0] res, input logic [31:0] st, input logic [4:0] rd,
                         input logic mr, input logic mw, input logic rw, input logic wd,
                         input int dly, input logic [31:0] rdat,
                         input logic expReq, input logic [3:0] expBe, input logic [31:0] expWd,
                         input int expStall, input logic [31:0] expRead,
                         input logic expRw, input logic expM2r, input logic expMis, input logic expErr);
        int n;
        bit done;
        wbExp_t e;
        reqExp_t r;
        e.result = res; e.readData = expRead; e.rd = rd; e.regWrite = expRw;
        e.memToReg = expM2r; e.mis = expMis; e.err = expErr;
        expQ.push_back(e);
        if (expReq) begin
            r.addr = {res[31:2], 2'b00}; r.be = expBe; r.wd = expWd; r.we = mw;
            reqQ.push_back(r);
        end
        ackDelay = dly;
        ackData = rdat;
        @(posedge clock); #1;
        drive(res, st, rd, mr, mw, rw, wd, 1'b1);
        n = 0;
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!stall) begin
                done = 1;
                break;
            end
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_stall_bound: got stall stuck expected release", name);
        end
        check({name, "_stall_cycles"}, n, expStall);
        @(posedge clock); #1;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_memReq", {31'd0, memReq}, 32'd0);
        check("rst_busErr", {31'd0, busErr}, 32'd0);
        check("rst_outRegWrite", {31'd0, outRegWrite}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_outResult", outResult, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        //     name      result        store         rd  mr mw rw wd dly rdata         req be     wdata         stl rdExp         rw m2r mis err
        issue("alu",     32'h0000_1234, 32'h0,        5, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 32'h0,        0,  32'h0,        1, 0,  0,  0);
        issue("lw",      32'h0000_0100, 32'h0,        3, 1, 0, 1, 1, 3, 32'hDEAD_BEEF, 1, 4'hF, 32'h0,        4,  32'hDEAD_BEEF, 1, 1,  0,  0);
        issue("sb",      32'h0000_0203, 32'h0000_00AB, 4, 0, 1, 0, 0, 1, 32'h0,        1, 4'h8, 32'hABAB_ABAB, 2,  32'hDEAD_BEEF, 0, 0,  0,  0);
        issue("lb",      32'h0000_0201, 32'h0,        7, 1, 0, 1, 0, 2, 32'h11C3_2233, 1, 4'h2, 32'h0,        3,  32'h0000_0022, 1, 1,  0,  0);
        issue("sw",      32'h0000_0208, 32'hCAFE_F00D, 8, 1, 1, 1, 1, 1, 32'h0,        1, 4'hF, 32'hCAFE_F00D, 2,  32'h0000_0022, 1, 0,  0,  0);
        issue("lw_mis",  32'h0000_0102, 32'h0,        9, 1, 0, 1, 1, 0, 32'h0,        0, 4'h0, 32'h0,        0,  32'h0000_0022, 0, 0,  1,  0);
        issue("lw_tmo",  32'h0000_0300, 32'h0,       10, 1, 0, 1, 1, 0, 32'h0,        1, 4'hF, 32'h0,        17, 32'h0000_0022, 0, 1,  0,  1);
        issue("alu_err", 32'h0000_0055, 32'h0,       11, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 32'h0,        0,  32'h0000_0022, 1, 0,  0,  1);

        // Reset pulsed while a load is outstanding
        begin
            reqExp_t r;
            r.addr = 32'h0000_0400; r.be = 4'hF; r.wd = 32'h0; r.we = 1'b0;
            reqQ.push_back(r);
            ackDelay = 0;
            @(posedge clock); #1;
            drive(32'h0000_0400, 32'h0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            repeat (3) @(negedge clock);
            check("midreq_memReq", {31'd0, memReq}, 32'd1);
            #2;
            reset_n = 1'b0;
            drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check("rstreq_memReq", {31'd0, memReq}, 32'd0);
            check("rstreq_busErr", {31'd0, busErr}, 32'd0);
            check("rstreq_stall", {31'd0, stall}, 32'd0);
            check("rstreq_outRegWrite", {31'd0, outRegWrite}, 32'd0);
            $display("reset mid-REQ memReq=%b busErr=%b stall=%b", memReq, busErr, stall);
            repeat (2) @(posedge clock);
            @(negedge clock);
            reset_n = 1'b1;
            repeat (2) @(posedge clock);
            check("postrst_memReq", {31'd0, memReq}, 32'd0);
        end

        issue("alu_rst", 32'h0000_0099, 32'h0,       12, 0, 0, 1, 1, 0, 32'h0,        0, 4'h0, 32'h0,        0,  32'h0,        1, 0,  0,  0);

        repeat (4) @(posedge clock);
        check("expQ_drained", expQ.size(), 32'd0);
        check("reqQ_drained", reqQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register. It reads the stage outputs: ALU result, store data, MemRead, MemWrite, Word, RegWrite and Rd.
- Runs a multi-cycle request/acknowledge transaction on the data-memory port and stalls upstream while the transaction is outstanding.
- Drives the MEM/WB-side registered outputs.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
- TIMEOUT, 16, max cycles in REQ without memAck before bus error (>=2).
- ADDR_W, 32, data-memory address width.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- inResult  in  32  ALU result / memory address from EX/MEM
- inReadRegister2  in  32  store data from EX/MEM
- inMemRead  in  1  load request (control bit 2)
- inMemWrite  in  1  store request (control bit 4)
- inRegWrite  in  1  writeback enable (control bit 6)
- inWord  in  1  1 = word access, 0 = byte access (control bit 8)
- inRd  in  5  destination register
- stall  out  1  combinational; 1 = hold EX/MEM and earlier stages
- memReq  out  1  registered memory request
- memWe  out  1  registered write enable
- memAddr  out  ADDR_W  word-aligned address, inResult with [1:0] forced to 0
- memWData  out  32  store data, replicated per byte lane
- memByteEn  out  4  byte enables
- memRData  in  32  read data, valid with memAck
- memAck  in  1  one-cycle acknowledge
- outResult  out  32  registered ALU result
- outReadData  out  32  registered load data
- outRd  out  5  registered destination register
- outRegWrite  out  1  registered writeback enable
- outMemToReg  out  1  registered; 1 = WB selects outReadData
- misalign  out  1  one-cycle pulse on misaligned word access
- busErr  out  1  sticky timeout error, cleared only by reset

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all registered outputs 0, including memReq, busErr, outRegWrite and counter. memReq drops immediately, including mid-transaction. No partial transaction resumes after reset.
- access = inMemRead | inMemWrite. If both are set, the instruction is treated as a write.
- States: IDLE, REQ, DONE.
- stall = (state==IDLE & access & aligned) | (state==REQ). stall is 0 in DONE, so EX/MEM advances on the DONE exit edge.
- aligned = ~inWord | (inResult[1:0]==0).
- IDLE, no access: at each edge outResult<=inResult, outRd<=inRd, outRegWrite<=inRegWrite, outMemToReg<=0. Latency is 1 cycle.
- IDLE, access, misaligned word:
  - no memory request, no stall
  - misalign=1 for one cycle
  - outRegWrite<=0 (instruction squashed)
  - state stays IDLE
- IDLE, aligned access, at the edge:
  - latch address, data, byte enables, Rd, RegWrite and read/write type
  - memReq<=1, memWe<=write
  - counter<=0
  - go to REQ
  - outRegWrite<=0 (bubble)
- REQ:
  - outRegWrite held 0; counter increments each cycle.
  - memAck=1: memReq<=0, capture the extracted load data, go to DONE.
  - counter==TIMEOUT-1 and no ack: memReq<=0, busErr<=1, go to DONE with writeback squashed.
  - memAck and timeout in the same cycle: the ack wins and there is no error.
- DONE, at the edge:
  - outResult, outRd and outReadData updated.
  - outRegWrite<=latched RegWrite & ~error.
  - outMemToReg<=latched read.
  - return to IDLE.
- Memory-op latency, EX/MEM presentation to MEM/WB valid: 2 + (cycles until ack).
- memAck outside REQ is ignored.
- Byte access, lane = inResult[1:0]:
  - memByteEn = 1<<lane
  - memWData = {4{store[7:0]}}
  - load = zero-extended memRData[8*lane+7 : 8*lane]
- Word access: memByteEn=4'hF; data is passed unmodified.

Decomposition:
- Package mem_access_pkg holds:
  - state enum: IDLE=2'd0, REQ=2'd1, DONE=2'd2
  - control-bit index constants: MEMREAD=2, MEMWRITE=4, REGWRITE=6, WORD=8
  - byte-enable constants
- Sub-module mem_byte_lane, combinational: byte-enable generation, store replication and load extraction. The FSM and registers stay in mem_access_unit.

Test Plan:
- ALU op with inRegWrite=1, inRd=5, inResult=0x1234, no access -> next edge outResult=0x1234, outRd=5, outRegWrite=1, stall=0 throughout.
- Word load at addr 0x100, memAck 3 cycles after memReq, memRData=0xDEADBEEF -> stall high for 4 cycles; memAddr=0x100, memByteEn=F; DONE edge gives outReadData=0xDEADBEEF, outMemToReg=1, outRegWrite=1.
- Byte store at 0x203, data 0xAB -> memByteEn=4'b1000, memWData=0xABABABAB, memWe=1; after ack outRegWrite=0.
- Byte load at 0x201 with memRData=0x11C3_2233 -> outReadData=0x00000022.
- Word load at 0x102 -> misalign pulse, memReq stays 0, stall=0, outRegWrite=0.
- TIMEOUT=16 with no ack -> memReq drops after 16 REQ cycles, busErr=1 sticky, outRegWrite=0. Separately, reset_n pulsed low mid-REQ -> memReq=0 immediately, state IDLE, busErr=0.
